// File: rtl/adc_align_if.sv
// Signal bundle between the ADC LVDS capture path and its alignment sequencer.
// slave: the sequencer; master: the capture path / system side.
interface adc_align_if;
   logic        adc_en;
   logic        realign;
   logic [7:0]  frm_data;
   logic        serdes_rst;
   logic        bitslip;
   logic        locked;
   logic        align_err;
   logic [3:0]  slip_cnt;
   logic [15:0] lock_loss_cnt;

   modport master (
      output adc_en, realign, frm_data,
      input  serdes_rst, bitslip, locked, align_err,
      input  slip_cnt, lock_loss_cnt
   );

   modport slave (
      input  adc_en, realign, frm_data,
      output serdes_rst, bitslip, locked, align_err,
      output slip_cnt, lock_loss_cnt
   );
endinterface

// File: rtl/adc_align_ctrl.sv
// ISERDES reset / bitslip sequencer aligning the ADC frame word to FRAME_PATTERN.
// Define ADC_ALIGN_STATS_EN to keep the saturating lock-loss event counter.
module adc_align_ctrl #(
   parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
   parameter int unsigned RST_CYCLES    = 10,
   parameter int unsigned SLIP_WAIT     = 3,
   parameter int unsigned LOCK_COUNT    = 16,
   parameter int unsigned LOSS_COUNT    = 4,
   parameter int unsigned MAX_SLIPS     = 8
) (
   input  logic      CLKDIV,
   input  logic      cpu_resetn,
   adc_align_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_SETTLE,
      S_CHECK,
      S_SLIP,
      S_LOCKED
   } state_t;

   localparam logic [7:0] LP_RST_LAST  = 8'(RST_CYCLES - 1);
   localparam logic [7:0] LP_WAIT_LAST = 8'(SLIP_WAIT - 1);
   localparam logic [7:0] LP_LOCK_LAST = 8'(LOCK_COUNT - 1);
   localparam logic [7:0] LP_LOSS_LAST = 8'(LOSS_COUNT - 1);
   localparam logic [3:0] LP_MAX_SLIPS = 4'(MAX_SLIPS);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [7:0] r_match;
   logic [7:0] r_miss;
   logic [3:0] r_slip_cnt;
   logic       r_serdes_rst;
   logic       r_bitslip;
   logic       r_locked;
   logic       r_align_err;
   logic       w_match;

   assign w_match = (bus.frm_data == FRAME_PATTERN);

   always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         r_state      <= S_IDLE;
         r_cnt        <= 8'd0;
         r_match      <= 8'd0;
         r_miss       <= 8'd0;
         r_slip_cnt   <= 4'd0;
         r_serdes_rst <= 1'b1;
         r_bitslip    <= 1'b0;
         r_locked     <= 1'b0;
         r_align_err  <= 1'b0;
      end else begin
         r_bitslip <= 1'b0;
         if (!bus.adc_en) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_match      <= 8'd0;
            r_miss       <= 8'd0;
            r_slip_cnt   <= 4'd0;
            r_serdes_rst <= 1'b1;
            r_locked     <= 1'b0;
            r_align_err  <= 1'b0;
         end else if (bus.realign && r_state != S_IDLE) begin
            r_state      <= S_RST;
            r_cnt        <= 8'd0;
            r_match      <= 8'd0;
            r_miss       <= 8'd0;
            r_slip_cnt   <= 4'd0;
            r_serdes_rst <= 1'b1;
            r_locked     <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  r_state      <= S_RST;
                  r_cnt        <= 8'd0;
                  r_match      <= 8'd0;
                  r_slip_cnt   <= 4'd0;
                  r_serdes_rst <= 1'b1;
               end
               S_RST: begin
                  if (r_cnt == LP_RST_LAST) begin
                     r_state      <= S_SETTLE;
                     r_cnt        <= 8'd0;
                     r_serdes_rst <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               S_SETTLE: begin
                  if (r_cnt == LP_WAIT_LAST) begin
                     r_state <= S_CHECK;
                     r_cnt   <= 8'd0;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               S_CHECK: begin
                  if (w_match) begin
                     if (r_match == LP_LOCK_LAST) begin
                        r_state  <= S_LOCKED;
                        r_match  <= 8'd0;
                        r_miss   <= 8'd0;
                        r_locked <= 1'b1;
                     end else begin
                        r_match <= r_match + 8'd1;
                     end
                  end else begin
                     r_match <= 8'd0;
                     if (r_slip_cnt < LP_MAX_SLIPS) begin
                        r_state    <= S_SLIP;
                        r_bitslip  <= 1'b1;
                        r_slip_cnt <= r_slip_cnt + 4'd1;
                     end else begin
                        // every slip position failed: start over from an ISERDES reset
                        r_state      <= S_RST;
                        r_cnt        <= 8'd0;
                        r_slip_cnt   <= 4'd0;
                        r_serdes_rst <= 1'b1;
                        r_align_err  <= 1'b1;
                     end
                  end
               end
               S_SLIP: begin
                  r_state <= S_SETTLE;
                  r_cnt   <= 8'd0;
               end
               S_LOCKED: begin
                  if (w_match) begin
                     r_miss <= 8'd0;
                  end else if (r_miss == LP_LOSS_LAST) begin
                     r_state    <= S_CHECK;
                     r_miss     <= 8'd0;
                     r_match    <= 8'd0;
                     r_slip_cnt <= 4'd0;
                     r_locked   <= 1'b0;
                  end else begin
                     r_miss <= r_miss + 8'd1;
                  end
               end
               default: begin
                  r_state      <= S_IDLE;
                  r_serdes_rst <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.serdes_rst = r_serdes_rst;
   assign bus.bitslip    = r_bitslip;
   assign bus.locked     = r_locked;
   assign bus.align_err  = r_align_err;
   assign bus.slip_cnt   = r_slip_cnt;

`ifdef ADC_ALIGN_STATS_EN
   logic [15:0] r_loss_cnt;
   logic        w_loss_evt;

   // counted even when a simultaneous realign overrides the CHECK transition
   assign w_loss_evt = bus.adc_en && (r_state == S_LOCKED) &&
                       !w_match && (r_miss == LP_LOSS_LAST);

   always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         r_loss_cnt <= 16'h0000;
      end else if (w_loss_evt && r_loss_cnt != 16'hFFFF) begin
         r_loss_cnt <= r_loss_cnt + 16'd1;
      end
   end

   assign bus.lock_loss_cnt = r_loss_cnt;
`else
   assign bus.lock_loss_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_adc_align_ctrl.sv
// Directed/randomized bench for adc_align_ctrl with a rotating-frame channel model.
// Expected timings come from the phase-length arithmetic of the alignment procedure.
module tb_adc_align_ctrl;
   localparam logic [7:0] PAT = 8'hF0;
   localparam int RST_C  = 10;
   localparam int SW     = 3;
   localparam int LOCK_C = 16;
   localparam int LOSS_C = 4;
   localparam int MAX_S  = 8;

   logic CLKDIV = 1'b0;
   logic cpu_resetn;

   adc_align_if bus ();

   adc_align_ctrl dut (
      .CLKDIV     (CLKDIV),
      .cpu_resetn (cpu_resetn),
      .bus        (bus)
   );

   always #5 CLKDIV = ~CLKDIV;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_pulses = 0;
   int last_bs = -1000;
   int min_gap = 1000;
   int wide = 0;
   int slips_seen = 0;
   int exp_loss = 0;
   bit prev_bs = 1'b0;
   bit rot_on = 1'b0;
   logic [7:0] base = 8'h00;

   function automatic logic [7:0] rotl(logic [7:0] v, int n);
      int s;
      s = n % 8;
      return (v << s) | (v >> (8 - s));
   endfunction

   function automatic logic [7:0] rand_bad();
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      if (v == PAT) v = ~v;
      return v;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one clock; a bitslip pulse rotates the modelled frame word by one bit
   task automatic tick();
      @(posedge CLKDIV);
      #1;
      cyc++;
      if (bus.bitslip) begin
         if (prev_bs) wide++;
         if (cyc - last_bs < min_gap) min_gap = cyc - last_bs;
         last_bs = cyc;
         n_pulses++;
         if (rot_on) begin
            slips_seen++;
            bus.frm_data = rotl(base, slips_seen);
         end
      end
      prev_bs = bus.bitslip;
   endtask

   task automatic clr_stats();
      n_pulses = 0;
      min_gap  = 1000;
      wide     = 0;
      last_bs  = -1000;
   endtask

   task automatic measure(output int lock_cyc, output int rst_hi);
      bit low_seen;
      low_seen = 1'b0;
      lock_cyc = -1;
      rst_hi   = 0;
      for (int n = 1; n <= 400; n++) begin
         tick();
         bus.realign = 1'b0;
         if (!low_seen && bus.serdes_rst) rst_hi++;
         else low_seen = 1'b1;
         if (bus.locked) begin
            lock_cyc = n;
            break;
         end
      end
   endtask

   // frame starts k slips away from PAT; alignment triggered by adc_en or realign
   task automatic align_run(string pfx, int k, bit by_realign);
      int lc;
      int rh;
      int exp_lc;
      base = rotl(PAT, (8 - k) % 8);
      slips_seen = 0;
      rot_on = 1'b1;
      bus.frm_data = base;
      clr_stats();
      if (by_realign) bus.realign = 1'b1;
      else bus.adc_en = 1'b1;
      measure(lc, rh);
      exp_lc = RST_C + SW + k * (SW + 2) + LOCK_C + 1;
      check({pfx, ".lock_cycle"}, lc, exp_lc);
      check({pfx, ".rst_cycles"}, rh, RST_C);
      check({pfx, ".pulses"}, n_pulses, k);
      check({pfx, ".slip_cnt"}, bus.slip_cnt, k);
      check({pfx, ".pulse_width"}, wide, 0);
      if (k >= 2) check({pfx, ".pulse_gap_ok"}, min_gap >= SW + 1, 1);
   endtask

   initial begin
      int k;
      int err_cyc;
      int max_slip;
      int rst_run;
      bit rst_low;
      bit lk_seen;
      bit rst_seen;
      bit got;

      cpu_resetn = 1'b0;
      bus.adc_en = 1'b0;
      bus.realign = 1'b0;
      bus.frm_data = PAT;
      repeat (3) @(posedge CLKDIV);
      #1;
      check("rst.serdes_rst", bus.serdes_rst, 1);
      check("rst.bitslip", bus.bitslip, 0);
      check("rst.locked", bus.locked, 0);
      check("rst.align_err", bus.align_err, 0);
      check("rst.slip_cnt", bus.slip_cnt, 0);
      check("rst.lock_loss_cnt", bus.lock_loss_cnt, 0);

      cpu_resetn = 1'b1;
      tick();
      tick();
      check("idle.serdes_rst", bus.serdes_rst, 1);

      align_run("const_f0", 0, 1'b0);
      align_run("realign_k3", 3, 1'b1);
      for (int i = 0; i < 2; i++) begin
         k = $urandom_range(1, 7);
         align_run($sformatf("rand_k%0d", k), k, 1'b1);
      end

      rot_on = 1'b0;
      for (int i = 0; i < LOSS_C - 1; i++) begin
         bus.frm_data = rand_bad();
         tick();
      end
      check("loss.short_burst_locked", bus.locked, 1);
      bus.frm_data = PAT;
      tick();
      check("loss.recover_locked", bus.locked, 1);
      for (int i = 0; i < LOSS_C; i++) begin
         bus.frm_data = rand_bad();
         tick();
         if (i == LOSS_C - 2) check("loss.before_last", bus.locked, 1);
      end
`ifdef ADC_ALIGN_STATS_EN
      exp_loss++;
`endif
      check("loss.locked", bus.locked, 0);
      check("loss.serdes_rst", bus.serdes_rst, 0);
      check("loss.slip_cnt", bus.slip_cnt, 0);
      check("loss.lock_loss_cnt", bus.lock_loss_cnt, exp_loss);
      bus.frm_data = PAT;
      rst_seen = 1'b0;
      for (int i = 0; i < LOCK_C - 1; i++) begin
         tick();
         rst_seen |= bus.serdes_rst;
      end
      check("loss.relock_early", bus.locked, 0);
      tick();
      check("loss.relock", bus.locked, 1);
      check("loss.no_serdes_rst", rst_seen, 0);

      for (int i = 0; i < LOSS_C - 1; i++) begin
         bus.frm_data = rand_bad();
         tick();
      end
      bus.frm_data = rand_bad();
      bus.realign = 1'b1;
      tick();
      bus.realign = 1'b0;
`ifdef ADC_ALIGN_STATS_EN
      exp_loss++;
`endif
      check("loss_realign.serdes_rst", bus.serdes_rst, 1);
      check("loss_realign.locked", bus.locked, 0);
      check("loss_realign.lock_loss_cnt", bus.lock_loss_cnt, exp_loss);
      check("loss_realign.align_err", bus.align_err, 0);

      // this cycle is the first RST cycle of the attempt
      bus.frm_data = 8'hAA;
      clr_stats();
      err_cyc = -1;
      max_slip = 0;
      lk_seen = 1'b0;
      for (int n = 2; n <= 300; n++) begin
         tick();
         if (int'(bus.slip_cnt) > max_slip) max_slip = int'(bus.slip_cnt);
         lk_seen |= bus.locked;
         if (bus.align_err) begin
            err_cyc = n;
            break;
         end
      end
      check("aa.err_cycle", err_cyc, RST_C + SW + MAX_S * (SW + 2) + 2);
      check("aa.pulses", n_pulses, MAX_S);
      check("aa.max_slip_cnt", max_slip, MAX_S);
      check("aa.serdes_rst", bus.serdes_rst, 1);
      rst_run = 1;
      rst_low = 1'b0;
      for (int n = 0; n < RST_C + SW + MAX_S * (SW + 2) + 1; n++) begin
         tick();
         lk_seen |= bus.locked;
         if (!rst_low && bus.serdes_rst) rst_run++;
         else rst_low = 1'b1;
      end
      check("aa.rst_run", rst_run, RST_C);
      check("aa.pulses_2nd", n_pulses, 2 * MAX_S);
      check("aa.align_err_sticky", bus.align_err, 1);
      check("aa.serdes_rst_2nd", bus.serdes_rst, 1);
      check("aa.never_locked", lk_seen, 0);
      check("aa.pulse_width", wide, 0);

      got = 1'b0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (bus.bitslip) begin
            got = 1'b1;
            break;
         end
      end
      check("en_drop.slip_seen", got, 1);
      bus.adc_en = 1'b0;
      tick();
      check("en_drop.serdes_rst", bus.serdes_rst, 1);
      check("en_drop.locked", bus.locked, 0);
      check("en_drop.align_err", bus.align_err, 0);
      check("en_drop.slip_cnt", bus.slip_cnt, 0);
      clr_stats();
      repeat (20) tick();
      check("en_drop.no_pulses", n_pulses, 0);
      check("en_drop.serdes_rst_held", bus.serdes_rst, 1);

      align_run("reen_f0", 0, 1'b0);
      cpu_resetn = 1'b0;
      #2;
      check("async_rst.serdes_rst", bus.serdes_rst, 1);
      check("async_rst.locked", bus.locked, 0);
      check("async_rst.lock_loss_cnt", bus.lock_loss_cnt, 0);
      tick();
      bus.adc_en = 1'b0;
      cpu_resetn = 1'b1;
      clr_stats();
      repeat (10) tick();
      check("post_rst.no_pulses", n_pulses, 0);
      check("post_rst.serdes_rst", bus.serdes_rst, 1);
      check("post_rst.align_err", bus.align_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
